// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch-in-ID operand hazards,
// multi-cycle mult/div occupancy of EX, plus a saturating stall-cycle counter.
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  IF_ID_rs,
    input  logic [4:0]  IF_ID_rt,
    input  logic        IF_ID_usesRt,
    input  logic        ID_isBranch,
    input  logic        ID_branchTaken,
    input  logic        ID_EX_memRead,
    input  logic        ID_EX_regWrite,
    input  logic [4:0]  ID_EX_writeReg,
    input  logic        EX_MEM_memRead,
    input  logic [4:0]  EX_MEM_writeReg,
    input  logic        EX_mdStart,
    input  logic        stat_clear,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_write,
    output logic        ID_EX_bubble,
    output logic        EX_MEM_bubble,
    output logic        md_busy,
    output logic [15:0] stall_count
);

    typedef enum logic {
        IDLE    = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] MD_INIT = 8'(MD_LATENCY - 2);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [15:0] r_stall_count;

    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem;
    logic w_data_stall;
    logic w_md_freeze;

    function automatic logic src_match(input logic [4:0] r, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    always_comb begin
        w_load_use   = ID_EX_memRead &&
                       src_match(ID_EX_writeReg, IF_ID_rs, IF_ID_rt, IF_ID_usesRt);
        w_br_ex      = ID_isBranch && ID_EX_regWrite &&
                       src_match(ID_EX_writeReg, IF_ID_rs, IF_ID_rt, IF_ID_usesRt);
        w_br_mem     = ID_isBranch && EX_MEM_memRead &&
                       src_match(EX_MEM_writeReg, IF_ID_rs, IF_ID_rt, IF_ID_usesRt);
        w_data_stall = w_load_use || w_br_ex || w_br_mem;
        w_md_freeze  = ((r_state == IDLE) && EX_mdStart) ||
                       ((r_state == MD_BUSY) && (r_cnt != 8'd0));
    end

    // Freeze outranks data stalls; reset forces a clean, non-stalling pipeline view.
    always_comb begin
        PC_write      = 1'b1;
        IF_ID_write   = 1'b1;
        ID_EX_write   = 1'b1;
        ID_EX_bubble  = 1'b0;
        EX_MEM_bubble = 1'b0;
        IF_ID_flush   = 1'b0;
        md_busy       = 1'b0;
        if (rst_n) begin
            md_busy     = (r_state == MD_BUSY);
            IF_ID_flush = ID_branchTaken && !w_data_stall && !w_md_freeze;
            if (w_md_freeze) begin
                PC_write      = 1'b0;
                IF_ID_write   = 1'b0;
                ID_EX_write   = 1'b0;
                EX_MEM_bubble = 1'b1;
            end else if (w_data_stall) begin
                PC_write     = 1'b0;
                IF_ID_write  = 1'b0;
                ID_EX_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (EX_mdStart) begin
                        r_state <= MD_BUSY;
                        r_cnt   <= MD_INIT;
                    end
                end
                MD_BUSY: begin
                    if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
                    else               r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || stat_clear)
            r_stall_count <= 16'd0;
        else if (!PC_write && (r_stall_count != 16'hFFFF))
            r_stall_count <= r_stall_count + 16'd1;
    end

    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: combinational vector table plus multi-cycle sequences.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  IF_ID_rs, IF_ID_rt;
    logic        IF_ID_usesRt, ID_isBranch, ID_branchTaken;
    logic        ID_EX_memRead, ID_EX_regWrite;
    logic [4:0]  ID_EX_writeReg;
    logic        EX_MEM_memRead;
    logic [4:0]  EX_MEM_writeReg;
    logic        EX_mdStart, stat_clear;
    logic        PC_write, IF_ID_write, IF_ID_flush, ID_EX_write;
    logic        ID_EX_bubble, EX_MEM_bubble, md_busy;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    hazard_stall_unit #(.MD_LATENCY(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt), .IF_ID_usesRt(IF_ID_usesRt),
        .ID_isBranch(ID_isBranch), .ID_branchTaken(ID_branchTaken),
        .ID_EX_memRead(ID_EX_memRead), .ID_EX_regWrite(ID_EX_regWrite),
        .ID_EX_writeReg(ID_EX_writeReg),
        .EX_MEM_memRead(EX_MEM_memRead), .EX_MEM_writeReg(EX_MEM_writeReg),
        .EX_mdStart(EX_mdStart), .stat_clear(stat_clear),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_write(ID_EX_write), .ID_EX_bubble(ID_EX_bubble),
        .EX_MEM_bubble(EX_MEM_bubble), .md_busy(md_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Expected control word order: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble}
    localparam logic [5:0] RUN   = 6'b110100;
    localparam logic [5:0] FLUSH = 6'b111100;
    localparam logic [5:0] STALL = 6'b000110;
    localparam logic [5:0] FRZ   = 6'b000001;

    typedef struct {
        logic [4:0] rs, rt;
        logic       uses_rt, is_br, taken, ex_rd, ex_wr;
        logic [4:0] ex_reg;
        logic       mem_rd;
        logic [4:0] mem_reg;
        logic [5:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [5:0] ctl();
        return {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_bubble, EX_MEM_bubble};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        IF_ID_rs = 5'd0; IF_ID_rt = 5'd0; IF_ID_usesRt = 1'b0;
        ID_isBranch = 1'b0; ID_branchTaken = 1'b0;
        ID_EX_memRead = 1'b0; ID_EX_regWrite = 1'b0; ID_EX_writeReg = 5'd0;
        EX_MEM_memRead = 1'b0; EX_MEM_writeReg = 5'd0;
        EX_mdStart = 1'b0; stat_clear = 1'b0;
    endtask

    task automatic load_use_inputs();
        IF_ID_rs = 5'd8; ID_EX_memRead = 1'b1; ID_EX_regWrite = 1'b1; ID_EX_writeReg = 5'd8;
    endtask

    // Advance one rising edge and return to the falling edge for the next drive.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_count();
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
    endtask

    function automatic vec_t mk(input string name, input logic [4:0] rs, input logic [4:0] rt,
                                input logic ur, input logic br, input logic tk,
                                input logic exr, input logic exw, input logic [4:0] exreg,
                                input logic mr, input logic [4:0] mreg, input logic [5:0] exp);
        vec_t v;
        v.name = name; v.rs = rs; v.rt = rt; v.uses_rt = ur; v.is_br = br; v.taken = tk;
        v.ex_rd = exr; v.ex_wr = exw; v.ex_reg = exreg; v.mem_rd = mr; v.mem_reg = mreg;
        v.exp = exp;
        return v;
    endfunction

    initial begin
        int exp_stalls;

        vecs[0]  = mk("lu_rs",       8, 0, 0, 0, 0, 1, 1, 8, 0, 0, STALL);
        vecs[1]  = mk("lu_r0",       0, 0, 0, 0, 0, 1, 1, 0, 0, 0, RUN);
        vecs[2]  = mk("lu_rt_off",   1, 9, 0, 0, 0, 1, 1, 9, 0, 0, RUN);
        vecs[3]  = mk("lu_rt_on",    1, 9, 1, 0, 0, 1, 1, 9, 0, 0, STALL);
        vecs[4]  = mk("br_ex",       5, 0, 0, 1, 1, 0, 1, 5, 0, 0, STALL);
        vecs[5]  = mk("br_mem",      5, 0, 0, 1, 1, 0, 0, 0, 1, 5, STALL);
        vecs[6]  = mk("br_taken",    5, 0, 0, 1, 1, 0, 0, 0, 0, 0, FLUSH);
        vecs[7]  = mk("alu_no_br",   5, 0, 0, 0, 0, 0, 1, 5, 0, 0, RUN);
        vecs[8]  = mk("memld_no_br", 5, 0, 0, 0, 0, 0, 0, 0, 1, 5, RUN);
        vecs[9]  = mk("lu_kills_fl", 8, 0, 0, 0, 1, 1, 1, 8, 0, 0, STALL);
        vecs[10] = mk("br_r0",       0, 0, 0, 1, 1, 0, 1, 0, 1, 0, FLUSH);
        vecs[11] = mk("br_rt_mem",   3, 7, 1, 1, 0, 0, 0, 0, 1, 7, STALL);

        idle_inputs();
        rst_n = 1'b0;
        load_use_inputs();
        EX_mdStart = 1'b1;
        ID_branchTaken = 1'b1;
        @(negedge clk);
        #1;
        check("reset_ctl", 16'(ctl()), 16'(RUN));
        check("reset_md_busy", 16'(md_busy), 16'd0);
        step();
        check("reset_count", stall_count, 16'd0);
        rst_n = 1'b1;
        idle_inputs();
        step();

        // Combinational vector table, one cycle per vector
        clear_count();
        exp_stalls = 0;
        for (int i = 0; i < 12; i++) begin
            IF_ID_rs = vecs[i].rs; IF_ID_rt = vecs[i].rt; IF_ID_usesRt = vecs[i].uses_rt;
            ID_isBranch = vecs[i].is_br; ID_branchTaken = vecs[i].taken;
            ID_EX_memRead = vecs[i].ex_rd; ID_EX_regWrite = vecs[i].ex_wr;
            ID_EX_writeReg = vecs[i].ex_reg;
            EX_MEM_memRead = vecs[i].mem_rd; EX_MEM_writeReg = vecs[i].mem_reg;
            #1;
            check(vecs[i].name, 16'(ctl()), 16'(vecs[i].exp));
            if (vecs[i].exp[5] == 1'b0) exp_stalls++;
            step();
        end
        idle_inputs();
        #1;
        check("table_count", stall_count, 16'(exp_stalls));

        // Single load-use stall counts exactly one cycle
        clear_count();
        load_use_inputs();
        step();
        idle_inputs();
        #1;
        check("lu_count", stall_count, 16'd1);
        check("lu_release", 16'(ctl()), 16'(RUN));

        // Branch following a load: br_ex then br_mem, flush only on the third cycle
        ID_isBranch = 1'b1; ID_branchTaken = 1'b1; IF_ID_rs = 5'd5;
        ID_EX_memRead = 1'b1; ID_EX_regWrite = 1'b1; ID_EX_writeReg = 5'd5;
        #1;
        check("bl_cyc1", 16'(ctl()), 16'(STALL));
        step();
        ID_EX_memRead = 1'b0; ID_EX_regWrite = 1'b0; ID_EX_writeReg = 5'd0;
        EX_MEM_memRead = 1'b1; EX_MEM_writeReg = 5'd5;
        #1;
        check("bl_cyc2", 16'(ctl()), 16'(STALL));
        step();
        EX_MEM_memRead = 1'b0; EX_MEM_writeReg = 5'd0;
        #1;
        check("bl_cyc3", 16'(ctl()), 16'(FLUSH));
        step();
        idle_inputs();

        // Mult/div with a simultaneous load-use: 3 frozen cycles, then load-use shows through
        clear_count();
        EX_mdStart = 1'b1;
        load_use_inputs();
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("md_frz%0d", c), 16'(ctl()), 16'(FRZ));
            check($sformatf("md_busy%0d", c), 16'(md_busy), (c == 0) ? 16'd0 : 16'd1);
            step();
        end
        #1;
        check("md_last_ctl", 16'(ctl()), 16'(STALL));
        check("md_last_busy", 16'(md_busy), 16'd1);
        step();
        idle_inputs();
        #1;
        check("md_idle_ctl", 16'(ctl()), 16'(RUN));
        check("md_idle_busy", 16'(md_busy), 16'd0);
        check("md_count", stall_count, 16'd4);

        // Reset while MD_BUSY with cnt == 1
        EX_mdStart = 1'b1;
        step();
        step();
        #1;
        check("mdr_pre_busy", 16'(md_busy), 16'd1);
        check("mdr_pre_ctl", 16'(ctl()), 16'(FRZ));
        rst_n = 1'b0;
        #1;
        check("mdr_in_reset", 16'(ctl()), 16'(RUN));
        step();
        rst_n = 1'b1;
        EX_mdStart = 1'b0;
        #1;
        check("mdr_after_ctl", 16'(ctl()), 16'(RUN));
        check("mdr_after_busy", 16'(md_busy), 16'd0);
        check("mdr_after_count", stall_count, 16'd0);

        // Saturation of the stall counter, then clear while still stalling
        load_use_inputs();
        for (int n = 0; n < 65540; n++) @(posedge clk);
        @(negedge clk);
        check("sat_count", stall_count, 16'hFFFF);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        #1;
        check("clr_count", stall_count, 16'd0);
        step();
        #1;
        check("post_clr_count", stall_count, 16'd1);
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
